// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
// - Default widths and PC constants, also used by the fetch and EX stages.
// - FSM state encoding: RUN=0, REDIRECT=1, FLUSH=2.
// - Width of the flush down-counter, sized for 1..7 flush cycles.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int RESET_PC_DEF     = 0;
    localparam int PC_STEP_DEF      = 4;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int CNT_W_DEF        = 16;
    localparam int FCNT_W           = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // A taken target must be word aligned. Any set low bit is reported.
    function automatic logic low_bits_set(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Interface between the EX-stage branch logic / fetch port and the PC sequencer.
//   stall, branch_ex, alu_zero, branch_target : driven by the pipeline (master)
//   pc, pc_src, flush, misalign               : sequencer outputs (slave)
//   taken_cnt, branch_cnt                     : branch statistics (slave)
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              stall;
    logic              branch_ex;
    logic              alu_zero;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic              pc_src;
    logic              flush;
    logic              misalign;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  branch_cnt;

    modport master (
        output stall, branch_ex, alu_zero, branch_target,
        input  pc, pc_src, flush, misalign, taken_cnt, branch_cnt
    );

    modport slave (
        input  stall, branch_ex, alu_zero, branch_target,
        output pc, pc_src, flush, misalign, taken_cnt, branch_cnt
    );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating event counter for branch statistics.
//   clock : rising-edge clock
//   reset : asynchronous, active-high, clears the count
//   inc   : count one event on this edge
//   count : current value. It stops at all-ones and never wraps.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer and branch controller for the fetch stage.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : stall, branch_ex, alu_zero, branch_target in;
//                  pc, pc_src, flush, misalign, taken_cnt, branch_cnt out
// A taken branch seen in RUN holds the PC for one cycle (REDIRECT). It then
// loads the latched target and keeps flush asserted for FLUSH_CYCLES cycles in
// total. All outputs are registered.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEF),
    parameter int                PC_STEP      = PC_STEP_DEF,
    parameter int                FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int                CNT_W        = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    pc_sequencer_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_STEP_V = ADDR_W'(PC_STEP);
    // The REDIRECT cycle already accounts for one flush cycle.
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] pc_reg,       pc_next;
    logic [ADDR_W-1:0] tgt_reg,      tgt_next;
    logic [FCNT_W-1:0] fcnt_reg,     fcnt_next;
    logic              pc_src_reg,   pc_src_next;
    logic              flush_reg,    flush_next;
    logic              misalign_reg, misalign_next;

    logic taken;
    assign taken = bus.branch_ex && bus.alu_zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            pc_reg       <= RESET_PC;
            tgt_reg      <= '0;
            fcnt_reg     <= '0;
            pc_src_reg   <= 1'b0;
            flush_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            tgt_reg      <= tgt_next;
            fcnt_reg     <= fcnt_next;
            pc_src_reg   <= pc_src_next;
            flush_reg    <= flush_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tgt_next      = tgt_reg;
        fcnt_next     = fcnt_reg;
        pc_src_next   = 1'b0;
        flush_next    = flush_reg;
        misalign_next = misalign_reg;

        case (state_reg)
            ST_RUN: begin
                // A taken branch wins over stall. The PC holds while the target is latched.
                if (taken) begin
                    tgt_next      = {bus.branch_target[ADDR_W-1:2], 2'b00};
                    misalign_next = misalign_reg | low_bits_set(bus.branch_target[1:0]);
                    pc_src_next   = 1'b1;
                    flush_next    = 1'b1;
                    fcnt_next     = FCNT_INIT;
                    state_next    = ST_REDIRECT;
                end else if (!bus.stall) begin
                    pc_next = pc_reg + PC_STEP_V;
                end
            end
            ST_REDIRECT: begin
                // The target load ignores stall so the redirect is never lost.
                pc_next = tgt_reg;
                if (fcnt_reg == '0) begin
                    flush_next = 1'b0;
                    state_next = ST_RUN;
                end else begin
                    fcnt_next  = fcnt_reg - 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Wrong-path branches are ignored here. The flush length does not depend on stall.
                if (!bus.stall) begin
                    pc_next = pc_reg + PC_STEP_V;
                end
                if (fcnt_reg == '0) begin
                    flush_next = 1'b0;
                    state_next = ST_RUN;
                end else begin
                    fcnt_next = fcnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Statistics count only branches evaluated in RUN.
    // Index 0 counts all branches. Index 1 counts taken branches.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = (state_reg == ST_RUN) && bus.branch_ex;
    assign cnt_inc[1] = (state_reg == ST_RUN) && taken;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clock (clock),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.pc         = pc_reg;
    assign bus.pc_src     = pc_src_reg;
    assign bus.flush      = flush_reg;
    assign bus.misalign   = misalign_reg;
    assign bus.branch_cnt = cnt_val[0];
    assign bus.taken_cnt  = cnt_val[1];
endmodule
